// File: rtl/key_search_ctrl.sv
// Brute-force RC4 key-search controller: launches the core per key, snoops the
// decrypted-RAM writes and stops on all-lowercase/space plaintext. Optional: KEY_SEARCH_EARLY_ABORT_EN.
module key_search_ctrl #(
  parameter int unsigned      KEY_W   = 24,
  parameter logic [KEY_W-1:0] KEY_MIN = 24'h000000,
  parameter logic [KEY_W-1:0] KEY_MAX = 24'h3FFFFF,
  parameter int unsigned      MSG_LEN = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic [KEY_W-1:0] secret_key,
  output logic             core_start,
  input  logic             core_done,
  output logic             core_abort,
  input  logic             dec_wren,
  input  logic [4:0]       dec_address,
  input  logic [7:0]       dec_data,
  output logic             busy,
  output logic             found,
  output logic             exhausted,
  output logic [KEY_W-1:0] found_key,
  output logic [KEY_W-1:0] trial_count
);

  localparam int unsigned      CNT_W     = $clog2(MSG_LEN + 1);
  localparam logic [CNT_W-1:0] MSG_LEN_C = CNT_W'(MSG_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_CHECK, S_NEXT, S_FOUND, S_FAIL
  } state_t;

  state_t           state_q;
  logic [KEY_W-1:0] key_q;
  logic [KEY_W-1:0] found_key_q;
  logic [KEY_W-1:0] trial_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bad_q, bad_d;
  logic             core_start_q;
  logic             busy_q;
  logic             found_q;
  logic             exhausted_q;
`ifdef KEY_SEARCH_EARLY_ABORT_EN
  logic             abort_q;
`endif

  function automatic logic byte_ok(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  // Per-trial bookkeeping including the write of the current cycle, so a byte
  // arriving together with core_done is already folded in when CHECK looks.
  always_comb begin
    cnt_d = cnt_q;
    bad_d = bad_q;
    if (dec_wren) begin
      if (cnt_q != MSG_LEN_C) cnt_d = cnt_q + 1'b1;
      if (!byte_ok(dec_data) || (dec_address != cnt_q[4:0])) bad_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      key_q        <= KEY_MIN;
      found_key_q  <= '0;
      trial_q      <= '0;
      cnt_q        <= '0;
      bad_q        <= 1'b0;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
      found_q      <= 1'b0;
      exhausted_q  <= 1'b0;
`ifdef KEY_SEARCH_EARLY_ABORT_EN
      abort_q      <= 1'b0;
`endif
    end else begin
      core_start_q <= 1'b0;
`ifdef KEY_SEARCH_EARLY_ABORT_EN
      abort_q      <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            key_q        <= KEY_MIN;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            trial_q      <= '0;
            cnt_q        <= '0;
            bad_q        <= 1'b0;
            busy_q       <= 1'b1;
            core_start_q <= 1'b1;
            state_q      <= S_LAUNCH;
          end
        end
        S_LAUNCH: state_q <= S_WAIT;
        S_WAIT: begin
          cnt_q <= cnt_d;
          bad_q <= bad_d;
`ifdef KEY_SEARCH_EARLY_ABORT_EN
          if (bad_d && !bad_q) begin
            abort_q <= 1'b1;
            state_q <= S_CHECK;
          end else if (core_done) begin
            state_q <= S_CHECK;
          end
`else
          if (core_done) state_q <= S_CHECK;
`endif
        end
        S_CHECK: begin
          if (!bad_q && (cnt_q == MSG_LEN_C)) begin
            found_key_q <= key_q;
            found_q     <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_FOUND;
          end else begin
            trial_q <= trial_q + 1'b1;
            if (key_q == KEY_MAX) begin
              exhausted_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= S_FAIL;
            end else begin
              state_q <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          key_q        <= key_q + 1'b1;
          cnt_q        <= '0;
          bad_q        <= 1'b0;
          core_start_q <= 1'b1;
          state_q      <= S_LAUNCH;
        end
        // A start still held from the previous search must drop before re-arming.
        S_FOUND, S_FAIL: if (!start) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign secret_key  = key_q;
  assign core_start  = core_start_q;
  assign busy        = busy_q;
  assign found       = found_q;
  assign exhausted   = exhausted_q;
  assign found_key   = found_key_q;
  assign trial_count = trial_q;
`ifdef KEY_SEARCH_EARLY_ABORT_EN
  assign core_abort  = abort_q;
`else
  assign core_abort  = 1'b0;
`endif

endmodule
